// File: rtl/riscv_v_elastic_pipe_pkg.sv
// Shared definitions for the elastic valid/ready pipeline.
//
// Contents:
//   RISCV_V_NUM_BYTES_DATA / RISCV_V_DATA_W : default payload width
//   pipe_slot_t                             : one slot (valid bit + payload) at the default width
//   occ_width()                             : width of the occupancy counter, never below 1 bit
package riscv_v_elastic_pipe_pkg;

  localparam int RISCV_V_NUM_BYTES_DATA = 4;
  localparam int RISCV_V_DATA_W         = RISCV_V_NUM_BYTES_DATA * 8;

  typedef struct packed {
    logic                      v;
    logic [RISCV_V_DATA_W-1:0] d;
  } pipe_slot_t;

  // Bits needed to count 0..ns valid slots; a zero-stage pipe still gets a 1-bit port.
  function automatic int occ_width(input int ns);
    return ($clog2(ns + 1) > 0) ? $clog2(ns + 1) : 1;
  endfunction

endpackage

// File: rtl/riscv_v_elastic_pipe_if.sv
// Valid/ready handshake bundle carrying one payload word.
//
// Signals:
//   valid : producer holds a payload
//   ready : consumer accepts this cycle
//   data  : payload, DATA_W bits
// Modports:
//   master : producer side (drives valid/data, samples ready)
//   slave  : consumer side (samples valid/data, drives ready)
interface riscv_v_elastic_pipe_if
  import riscv_v_elastic_pipe_pkg::*;
#(
  parameter int DATA_W = RISCV_V_DATA_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/riscv_v_elastic_pipe_slot.sv
// One register slot of the elastic pipe: a valid bit and a payload register.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : clear valid, reload RST_VAL into the payload
//   kill              : clear valid; an incoming payload is dropped
//   load              : slot takes src_valid/src_data this cycle (ready chain says it may)
//   src_valid/src_data: what the upstream neighbour offers
//   valid/data        : slot contents
module riscv_v_elastic_pipe_slot
  import riscv_v_elastic_pipe_pkg::*;
#(
  parameter int                DATA_W  = RISCV_V_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              kill,
  input  logic              load,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Priority rst > flush > kill > load. The payload register only moves on a
  // real incoming transfer, so a held or drained slot keeps its last word.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= src_valid;
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/riscv_v_elastic_pipe.sv
// Elastic valid/ready pipeline of NUM_STAGES slots with backpressure,
// bubble collapsing, global enable, flush and per-slot kill.
//
// Parameters: DATA_W (payload width), NUM_STAGES (0 = combinational
// pass-through), RST_VAL (payload value after reset/flush).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : global advance enable, 0 freezes every slot
//   flush      : kill every slot; no input accepted in that cycle
//   kill_mask  : bit i kills slot i (slot 0 is the input side)
//   in_if      : upstream handshake (slave)
//   out_if     : downstream handshake (master)
//   occupancy  : number of valid slots, only when RISCV_V_PIPE_OCC_EN is defined
module riscv_v_elastic_pipe
  import riscv_v_elastic_pipe_pkg::*;
#(
  parameter int                DATA_W     = RISCV_V_DATA_W,
  parameter int                NUM_STAGES = 2,
  parameter logic [DATA_W-1:0] RST_VAL    = '0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       en,
  input  logic                                       flush,
  input  logic [(NUM_STAGES > 0 ? NUM_STAGES : 1)-1:0] kill_mask,
  riscv_v_elastic_pipe_if.slave                      in_if,
  riscv_v_elastic_pipe_if.master                     out_if
`ifdef RISCV_V_PIPE_OCC_EN
  ,
  output logic [occ_width(NUM_STAGES)-1:0]           occupancy
`endif
);

  localparam int NS = NUM_STAGES;

  if (NS == 0) begin : g_pass
    // No storage: the handshake passes straight through, gated by en.
    logic unused_ns0;
    assign unused_ns0   = ^{clk, rst, flush, kill_mask};
    assign in_if.ready  = out_if.ready & en;
    assign out_if.valid = in_if.valid & en;
    assign out_if.data  = in_if.data;
`ifdef RISCV_V_PIPE_OCC_EN
    assign occupancy    = '0;
`endif
  end else begin : g_pipe
    logic [NS:0]       ready;
    logic [NS-1:0]     slot_valid;
    logic [DATA_W-1:0] slot_data [NS];
    logic [NS-1:0]     src_valid;
    logic [DATA_W-1:0] src_data  [NS];

    // Ready chain from the output back to the input: a slot can take a new
    // payload if it is empty or its own payload leaves this cycle. Empty
    // slots stay ready while downstream stalls, which collapses bubbles.
    always_comb begin
      ready     = '0;
      ready[NS] = out_if.ready & en;
      for (int i = NS - 1; i >= 0; i--) begin
        ready[i] = en & (~slot_valid[i] | ready[i+1]);
      end
    end

    // What each slot is offered. A killed slot's payload is dropped rather
    // than forwarded, so kill removes the occupant even when it is moving.
    always_comb begin
      src_valid[0] = in_if.valid;
      src_data[0]  = in_if.data;
      for (int i = 1; i < NS; i++) begin
        src_valid[i] = slot_valid[i-1] & ~kill_mask[i-1];
        src_data[i]  = slot_data[i-1];
      end
    end

    for (genvar i = 0; i < NS; i++) begin : g_slot
      riscv_v_elastic_pipe_slot #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .kill      (kill_mask[i]),
        .load      (ready[i]),
        .src_valid (src_valid[i]),
        .src_data  (src_data[i]),
        .valid     (slot_valid[i]),
        .data      (slot_data[i])
      );
    end

    // in_ready is masked by flush so nothing is accepted into a pipe that is
    // being cleared; a killed last slot is hidden from the consumer.
    assign in_if.ready  = ready[0] & ~flush;
    assign out_if.valid = slot_valid[NS-1] & ~kill_mask[NS-1];
    assign out_if.data  = slot_data[NS-1];

    // Producers must hold a stalled offer unchanged until it is taken.
    a_in_hold: assert property (@(posedge clk) disable iff (rst)
      (in_if.valid && !in_if.ready) |=> (in_if.valid && $stable(in_if.data)));

`ifdef RISCV_V_PIPE_OCC_EN
    localparam int OCC_W = occ_width(NS);
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_drop;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_if.valid & in_if.ready;
    assign out_fire = out_if.valid & out_if.ready & en;

    // Payloads lost to kill: the current occupant of a killed slot, plus a
    // payload that was about to enter a killed slot.
    always_comb begin
      occ_drop = '0;
      for (int i = 0; i < NS; i++) begin
        occ_drop = occ_drop + OCC_W'(slot_valid[i] & kill_mask[i])
                            + OCC_W'(ready[i] & src_valid[i] & kill_mask[i]);
      end
    end

    // Running count of valid slots, kept arithmetically from the transfers.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_q + OCC_W'(in_fire) - OCC_W'(out_fire) - occ_drop;
      end
    end

    assign occupancy = occ_q;

    a_occ_match: assert property (@(posedge clk) disable iff (rst)
      occ_q == OCC_W'($countones(slot_valid)));
`endif
  end

endmodule

// File: tb/tb_riscv_v_elastic_pipe.sv
// Self-checking bench for riscv_v_elastic_pipe (NUM_STAGES=3, DATA_W=32) plus a
// NUM_STAGES=0 pass-through instance. A queue-walk reference model predicts
// in_ready/out_valid/out_data (and occupancy with RISCV_V_PIPE_OCC_EN) every cycle.
module tb_riscv_v_elastic_pipe;
  import riscv_v_elastic_pipe_pkg::*;

  localparam int NS = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst, en, flush;
  logic [NS-1:0] kill_mask;
  logic [0:0]    p_kill;

  riscv_v_elastic_pipe_if #(.DATA_W(DW)) in_if ();
  riscv_v_elastic_pipe_if #(.DATA_W(DW)) out_if ();
  riscv_v_elastic_pipe_if #(.DATA_W(DW)) p_in_if ();
  riscv_v_elastic_pipe_if #(.DATA_W(DW)) p_out_if ();

`ifdef RISCV_V_PIPE_OCC_EN
  logic [occ_width(NS)-1:0] occupancy;
  logic [0:0]               p_occupancy;
`endif

  riscv_v_elastic_pipe #(.DATA_W(DW), .NUM_STAGES(NS), .RST_VAL('0)) dut (
    .clk (clk), .rst (rst), .en (en), .flush (flush), .kill_mask (kill_mask),
    .in_if (in_if), .out_if (out_if)
`ifdef RISCV_V_PIPE_OCC_EN
    , .occupancy (occupancy)
`endif
  );

  riscv_v_elastic_pipe #(.DATA_W(DW), .NUM_STAGES(0), .RST_VAL('0)) dut_pass (
    .clk (clk), .rst (rst), .en (en), .flush (flush), .kill_mask (p_kill),
    .in_if (p_in_if), .out_if (p_out_if)
`ifdef RISCV_V_PIPE_OCC_EN
    , .occupancy (p_occupancy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pipe_slot_t     model [NS];
  logic [DW-1:0]  txQ[$];
  logic [DW-1:0]  outLog[$];
  int             outCyc[$];
  int             accCyc[$];
  bit             pending = 1'b0;
  bit             idleReq = 1'b0;
  bit             passChk = 1'b0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: walk from the output end, letting each payload step
  // forward into a position that is empty or was vacated this cycle, then
  // admit the input into a free first position. Payloads sitting in a killed
  // slot die (even if they move), and killed positions end up empty.
  task automatic modelStep(input bit commit, output bit inRdy, output bit outFire);
    pipe_slot_t s [NS];
    bit dead [NS];
    s = model;
    for (int i = 0; i < NS; i++) dead[i] = kill_mask[i];
    inRdy = 1'b0;
    outFire = 1'b0;
    if (en) begin
      if (s[NS-1].v && out_if.ready) begin
        outFire = !dead[NS-1];
        s[NS-1].v = 1'b0;
        dead[NS-1] = 1'b0;
      end
      for (int i = NS - 2; i >= 0; i--) begin
        if (s[i].v && !s[i+1].v) begin
          s[i+1] = s[i];
          dead[i+1] = dead[i];
          s[i].v = 1'b0;
          dead[i] = 1'b0;
        end
      end
      inRdy = !flush && !s[0].v;
      if (inRdy && in_if.valid) begin
        s[0].v = 1'b1;
        s[0].d = in_if.data;
        dead[0] = 1'b0;
      end
    end
    for (int i = 0; i < NS; i++) if (dead[i] || kill_mask[i]) s[i].v = 1'b0;
    if (flush || rst) for (int i = 0; i < NS; i++) s[i].v = 1'b0;
    if (commit) model = s;
  endtask

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < NS; i++) if (model[i].v) n++;
    return n;
  endfunction

  task automatic runCycle();
    bit inRdy, oFire, expOv, acc;
    if (pending) begin
      in_if.valid = 1'b1;
      in_if.data  = txQ[0];
    end else if (txQ.size() > 0 && !idleReq) begin
      in_if.valid = 1'b1;
      in_if.data  = txQ[0];
    end else begin
      in_if.valid = 1'b0;
      in_if.data  = '0;
    end
    if (passChk) begin
      p_in_if.valid  = 1'($urandom);
      p_in_if.data   = $urandom;
      p_out_if.ready = 1'($urandom);
    end
    @(negedge clk);
    modelStep(1'b0, inRdy, oFire);
    expOv = model[NS-1].v && !kill_mask[NS-1];
    if (!rst) begin
      checkOutput("in_ready", in_if.ready, inRdy);
      checkOutput("out_valid", out_if.valid, expOv);
      if (expOv) checkOutput("out_data", out_if.data, model[NS-1].d);
`ifdef RISCV_V_PIPE_OCC_EN
      checkOutput("occupancy", occupancy, modelCount());
`endif
      if (passChk) begin
        checkOutput("ns0_in_ready", p_in_if.ready, p_out_if.ready & en);
        checkOutput("ns0_out_valid", p_out_if.valid, p_in_if.valid & en);
        checkOutput("ns0_out_data", p_out_if.data, p_in_if.data);
      end
    end
    acc = in_if.valid && in_if.ready;
    if (acc) accCyc.push_back(cyc);
    if (out_if.valid && out_if.ready && en) begin
      outLog.push_back(out_if.data);
      outCyc.push_back(cyc);
    end
    @(posedge clk);
    modelStep(1'b1, inRdy, oFire);
    if (acc) void'(txQ.pop_front());
    pending = in_if.valid && !acc;
    cyc++;
    #1;
  endtask

  task automatic applyStimulus(input bit e, input bit r, input bit f, input logic [NS-1:0] k,
                               input bit idle, input int n);
    en = e;
    out_if.ready = r;
    flush = f;
    kill_mask = k;
    idleReq = idle;
    for (int i = 0; i < n; i++) runCycle();
    flush = 1'b0;
    kill_mask = '0;
  endtask

  task automatic clearLogs();
    outLog.delete();
    outCyc.delete();
    accCyc.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; flush = 1'b0; kill_mask = '0; p_kill = '0;
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b1;
    p_in_if.valid = 1'b0; p_in_if.data = '0; p_out_if.ready = 1'b0;
    for (int i = 0; i < NS; i++) model[i] = '0;

    // Reset
    applyStimulus(1, 1, 0, '0, 1, 2);
    rst = 1'b0;
    #2;
    checkOutput("rst_out_valid", out_if.valid, 1'b0);
    checkOutput("rst_out_data", out_if.data, 32'h0);
    checkOutput("rst_in_ready", in_if.ready, 1'b1);
`ifdef RISCV_V_PIPE_OCC_EN
    checkOutput("rst_occupancy", occupancy, 0);
`endif

    // Streaming 0x1..0x10
    clearLogs();
    for (int i = 1; i <= 16; i++) txQ.push_back(i);
    applyStimulus(1, 1, 0, '0, 0, 24);
    checkOutput("stream_count", outLog.size(), 16);
    if (outLog.size() == 16 && accCyc.size() == 16) begin
      checkOutput("stream_latency", outCyc[0] - accCyc[0], 3);
      for (int i = 0; i < 16; i++) begin
        checkOutput("stream_data", outLog[i], i + 1);
        checkOutput("stream_gapless", outCyc[i], outCyc[0] + i);
      end
    end

    // Backpressure A,B,C,D
    clearLogs();
    txQ = '{32'hA, 32'hB, 32'hC, 32'hD};
    applyStimulus(1, 0, 0, '0, 0, 6);
    checkOutput("bp_accepts", accCyc.size(), 3);
    checkOutput("bp_in_ready", in_if.ready, 1'b0);
    applyStimulus(1, 1, 0, '0, 0, 8);
    checkOutput("bp_count", outLog.size(), 4);
    if (outLog.size() == 4)
      for (int i = 0; i < 4; i++) checkOutput("bp_order", outLog[i], 32'hA + i);

    // Bubble collapse
    clearLogs();
    txQ.push_back(32'h5);
    applyStimulus(1, 0, 0, '0, 0, 1);
    applyStimulus(1, 0, 0, '0, 1, 2);
    txQ.push_back(32'h6);
    applyStimulus(1, 0, 0, '0, 0, 3);
    checkOutput("bub_out_valid", out_if.valid, 1'b1);
    checkOutput("bub_out_data", out_if.data, 32'h5);
    checkOutput("bub_held", outLog.size(), 0);
`ifdef RISCV_V_PIPE_OCC_EN
    checkOutput("bub_occupancy", occupancy, 2);
`endif
    applyStimulus(1, 1, 0, '0, 0, 4);
    checkOutput("bub_count", outLog.size(), 2);
    if (outLog.size() == 2) begin
      checkOutput("bub_first", outLog[0], 32'h5);
      checkOutput("bub_second", outLog[1], 32'h6);
      checkOutput("bub_consecutive", outCyc[1], outCyc[0] + 1);
    end

    // Kill the middle slot of a full pipe
    clearLogs();
    txQ = '{32'h11, 32'h22, 32'h33};
    applyStimulus(1, 0, 0, '0, 0, 5);
`ifdef RISCV_V_PIPE_OCC_EN
    checkOutput("kill_occ_before", occupancy, 3);
`endif
    applyStimulus(1, 0, 0, 3'b010, 0, 1);
`ifdef RISCV_V_PIPE_OCC_EN
    checkOutput("kill_occ_after", occupancy, 2);
`endif
    applyStimulus(1, 1, 0, '0, 0, 5);
    checkOutput("kill_count", outLog.size(), 2);
    if (outLog.size() == 2) begin
      checkOutput("kill_first", outLog[0], 32'h11);
      checkOutput("kill_second", outLog[1], 32'h33);
    end

    // Flush with an offered input
    clearLogs();
    txQ = '{32'h44, 32'h55, 32'h66, 32'h77};
    applyStimulus(1, 0, 0, '0, 0, 5);
    n = accCyc.size();
    applyStimulus(1, 1, 1, '0, 0, 1);
    #1;
    checkOutput("flush_no_accept", accCyc.size(), n);
    checkOutput("flush_out_valid", out_if.valid, 1'b0);
    applyStimulus(1, 1, 0, '0, 0, 6);

    // en=0 freeze mid-stream
    clearLogs();
    for (int i = 1; i <= 8; i++) txQ.push_back(32'h100 + i);
    applyStimulus(1, 1, 0, '0, 0, 5);
    n = outLog.size();
    applyStimulus(0, 1, 0, '0, 0, 4);
    checkOutput("freeze_no_fire", outLog.size(), n);
    applyStimulus(1, 1, 0, '0, 0, 12);
    checkOutput("freeze_count", outLog.size(), 8);
    if (outLog.size() == 8)
      for (int i = 0; i < 8; i++) checkOutput("freeze_order", outLog[i], 32'h101 + i);

    // Randomised traffic against the model, plus the pass-through instance
    passChk = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (txQ.size() < 4) txQ.push_back($urandom);
      applyStimulus($urandom_range(9) != 0, $urandom_range(9) < 7, $urandom_range(49) == 0,
                    ($urandom_range(19) == 0) ? NS'($urandom) : '0, $urandom_range(3) == 0, 1);
    end
    passChk = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
